// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: named timing sets, polarity constants and
// the layout of the decoded sync bundle that travels through the delay line.
package vga_timing_pkg;

  // Sync polarity levels; a polarity constant is the *active* level.
  localparam logic POL_HIGH = 1'b1;
  localparam logic POL_LOW  = 1'b0;

  // Selector for the built-in timing sets.
  typedef enum logic [0:0] {
    MODE_SVGA_800X600_60 = 1'b0,
    MODE_VGA_640X480_60  = 1'b1
  } vga_mode_e;

  // One complete set of horizontal/vertical timing numbers.
  typedef struct packed {
    int unsigned h_display;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_display;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        h_pol;
    logic        v_pol;
    int unsigned pixel_khz;
  } vga_timing_t;

  // 800x600 at 60 Hz, 40 MHz pixel clock, positive syncs.
  localparam vga_timing_t SVGA_800X600_60 = '{
    h_display: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_display: 600, v_front: 1,  v_sync: 4,   v_back: 23,
    h_pol: POL_HIGH, v_pol: POL_HIGH,
    pixel_khz: 40000
  };

  // 640x480 at 60 Hz, 25.175 MHz pixel clock, negative syncs.
  localparam vga_timing_t VGA_640X480_60 = '{
    h_display: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_display: 480, v_front: 10, v_sync: 2,  v_back: 33,
    h_pol: POL_LOW, v_pol: POL_LOW,
    pixel_khz: 25175
  };

  // Look up a named timing set; unknown selectors fall back to 800x600.
  function automatic vga_timing_t timing_preset(input vga_mode_e mode);
    vga_timing_t t;
    case (mode)
      MODE_VGA_640X480_60:  t = VGA_640X480_60;
      MODE_SVGA_800X600_60: t = SVGA_800X600_60;
      default:              t = SVGA_800X600_60;
    endcase
    return t;
  endfunction

  // Timing set the generator uses when no parameters are overridden.
  localparam vga_timing_t DEFAULT_TIMING = timing_preset(MODE_SVGA_800X600_60);

  // Decoded per-position signals, delayed together as one bundle.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } vga_sync_t;

  localparam int SYNC_W = $bits(vga_sync_t);

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register of DEPTH stages, WIDTH bits wide, used to line up
// decoded timing signals with a downstream pixel pipeline. Every stage loads
// RST_VAL on reset so nothing stale leaks out after a reset release.
module sync_delay #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per enabled clock; all stages clear to RST_VAL on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RST_VAL;
      end
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical position counters, a
// completed-frame counter and sync/display-enable decode. The decoded signals
// are delayed by LATENCY enabled clocks; x and y are presented undelayed so a
// pixel pipeline of that depth can use them directly.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY = DEFAULT_TIMING.h_display,
  parameter int   H_FRONT   = DEFAULT_TIMING.h_front,
  parameter int   H_SYNC    = DEFAULT_TIMING.h_sync,
  parameter int   H_BACK    = DEFAULT_TIMING.h_back,
  parameter int   V_DISPLAY = DEFAULT_TIMING.v_display,
  parameter int   V_FRONT   = DEFAULT_TIMING.v_front,
  parameter int   V_SYNC    = DEFAULT_TIMING.v_sync,
  parameter int   V_BACK    = DEFAULT_TIMING.v_back,
  parameter logic H_POL     = DEFAULT_TIMING.h_pol,
  parameter logic V_POL     = DEFAULT_TIMING.v_pol,
  parameter int   LATENCY   = 1,
  parameter int   FRAME_W   = 16,
  localparam int  H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int  XW        = $clog2(H_TOTAL),
  localparam int  YW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Refuse to build with degenerate timing or an unsupported pipeline depth.
  if (H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_timing
    $error("vga_timing_gen: display, porch and sync lengths must all be non-zero");
  end
  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("vga_timing_gen: LATENCY must lie in 1..16");
  end

  // Decode boundaries sized to the counters. Every boundary is at most
  // TOTAL-1, so it always fits in the counter width.
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_VIS    = XW'(H_DISPLAY);
  localparam logic [XW-1:0] HS_START = XW'(H_DISPLAY + H_FRONT);
  localparam logic [XW-1:0] HS_END   = XW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_VIS    = YW'(V_DISPLAY);
  localparam logic [YW-1:0] VS_START = YW'(V_DISPLAY + V_FRONT);
  localparam logic [YW-1:0] VS_END   = YW'(V_DISPLAY + V_FRONT + V_SYNC);

  // Bundle value meaning "nothing happening": syncs idle, no pulses.
  localparam vga_sync_t SYNC_IDLE = '{
    hsync:       ~H_POL,
    vsync:       ~V_POL,
    de:          1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  vga_sync_t dec_now;
  vga_sync_t dec_dly;

  // Raster counters: x runs across the line, y steps at the end of each
  // line, and the frame counter steps when both wrap back to the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y         <= '0;
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Decode the current counter position into sync, enable and start pulses.
  always_comb begin
    dec_now             = SYNC_IDLE;
    dec_now.hsync       = ((x >= HS_START) && (x < HS_END)) ? H_POL : ~H_POL;
    dec_now.vsync       = ((y >= VS_START) && (y < VS_END)) ? V_POL : ~V_POL;
    dec_now.de          = (x < X_VIS) && (y < Y_VIS);
    dec_now.line_start  = (x == '0);
    dec_now.frame_start = (x == '0) && (y == '0);
  end

  sync_delay #(
    .DEPTH   (LATENCY),
    .WIDTH   (SYNC_W),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (dec_now),
    .dout (dec_dly)
  );

  assign hsync       = dec_dly.hsync;
  assign vsync       = dec_dly.vsync;
  assign de          = dec_dly.de;
  assign line_start  = dec_dly.line_start;
  assign frame_start = dec_dly.frame_start;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, 800, visible pixels per line.
REQ-002 Parameter H_FRONT, 40, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 128, hsync width in clocks.
REQ-004 Parameter H_BACK, 88, horizontal back porch in clocks.
REQ-005 Parameter V_DISPLAY, 600, visible lines per frame.
REQ-006 Parameter V_FRONT, 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 4, vsync width in lines.
REQ-008 Parameter V_BACK, 23, vertical back porch in lines.
REQ-009 Parameter H_POL, 1, hsync active level (1 = active-high).
REQ-010 Parameter V_POL, 1, vsync active level (1 = active-high).
REQ-011 Parameter LATENCY, 1, clocks from counter value to its decoded outputs (range 1..16).
REQ-012 Parameter FRAME_W, 16, frame counter width.
REQ-013 clk  in  1  pixel clock; one clock domain, all logic on rising edge.
REQ-014 rst  in  1  asynchronous, active-low reset.
REQ-015 en  in  1  advance enable; 0 freezes the whole block.
REQ-016 x  out  XW = clog2(H_TOTAL)  current horizontal counter.
REQ-017 y  out  YW = clog2(V_TOTAL)  current vertical counter.
REQ-018 hsync, vsync  out  1 each  decoded sync outputs at configured polarity.
REQ-019 de  out  1  display enable (visible pixel).
REQ-020 line_start, frame_start  out  1 each  single-clock pulses.
REQ-021 frame_cnt  out  FRAME_W  completed-frame count.

Function
REQ-022 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; x counts 0..H_TOTAL-1, y counts 0..V_TOTAL-1.
REQ-023 On a clock with en=1: x increments; at x=H_TOTAL-1, x wraps to 0 and y increments; at (H_TOTAL-1, V_TOTAL-1), both wrap to 0 and frame_cnt increments modulo 2^FRAME_W.
REQ-024 On a clock with en=0, x, y, frame_cnt, the delay pipeline and all outputs hold their values.
REQ-025 Decode of position (x,y): hsync active when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC; vsync active when V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC; de when x<H_DISPLAY and y<V_DISPLAY; line_start when x=0; frame_start when x=0 and y=0.
REQ-026 Decoded hsync, vsync, de, line_start and frame_start appear exactly LATENCY enabled clocks after the counter holds that position; x and y are not delayed.
REQ-027 Active hsync level = H_POL and inactive = ~H_POL; vsync uses V_POL in the same way.
REQ-028 Position (0,0) present at reset release is a genuine frame start and produces frame_start.
REQ-029 Elaboration fails if any porch/sync/display parameter is 0 or LATENCY is outside 1..16.

Reset
REQ-030 While rst=0, independent of clk: x=0, y=0, frame_cnt=0, hsync=~H_POL, vsync=~V_POL, de=0, line_start=0, frame_start=0, all pipeline stages inactive.
REQ-031 Asserting reset mid-frame takes effect immediately; after release, counting restarts from (0,0) without residual pulses from the pipeline.

Structure
REQ-032 Package vga_timing_pkg holds named timing constant sets (800x600@60/40 MHz default, 640x480@60/25.175 MHz) and the polarity constants.
REQ-033 Sub-module sync_delay (parametrised depth/width shift register, en, async active-low reset, reset value parameter) implements the LATENCY pipeline.

Verification
REQ-034 Defaults, en=1 -> 1056 clocks per line and 663168 per frame; hsync high for 128 clocks starting 841 clocks after release; de high for 800 clocks on lines 0..599 only.
REQ-035 H 4/1/2/1, V 3/1/1/1, H_POL=V_POL=0, LATENCY=3 -> hsync low exactly at x=5..6 delayed by 3 clocks; frame_start once per 48 clocks; first frame_start 3 clocks after release.
REQ-036 en toggled low for 17 clocks mid-line -> x, y and all outputs frozen; sequence resumes with no skipped or duplicated positions.
REQ-037 Reset asserted at x=500, y=300 -> all outputs reach reset values without a clock edge; first post-release frame_start appears after LATENCY clocks.
REQ-038 FRAME_W=2, 5 full frames -> frame_cnt sequence 1,2,3,0,1, each increment coinciding with the (0,0) counter wrap.
